// File: rtl/frame_write_ctrl.sv
// Write-side sequencer: packs a byte stream into 24-bit pixels and issues one
// write per pixel with raster coordinates, frame-done and resync reporting.
module frame_write_ctrl #(
    parameter int H_PIXELS = 110,
    parameter int V_LINES  = 110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_sof,
    output logic        byte_ready,
    input  logic        wr_ready,
    output logic        wr_en,
    output logic [23:0] wr_data,
    output logic [9:0]  wr_px,
    output logic [9:0]  wr_line,
    output logic        busy,
    output logic        frame_done,
    output logic        sync_err
);

    localparam logic [9:0] H_LAST = 10'(H_PIXELS - 1);
    localparam logic [9:0] V_LAST = 10'(V_LINES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACC, WRITE} state_t;

    state_t      state_reg;
    logic [1:0]  cnt_reg;
    logic [9:0]  px_reg;
    logic [9:0]  line_reg;
    logic        byte_ready_reg;
    logic        wr_en_reg;
    logic        busy_reg;
    logic        frame_done_reg;
    logic        sync_err_reg;
    logic [2:0]  lane_load;

    // A start-of-frame byte always lands in lane 0; otherwise the counter picks the lane.
    always_comb begin
        lane_load = 3'b000;
        if (byte_valid && (state_reg == WAIT_SOF || state_reg == ACC)) begin
            if (byte_sof) begin
                lane_load[0] = 1'b1;
            end else if (state_reg == ACC) begin
                case (cnt_reg)
                    2'd0:    lane_load[0] = 1'b1;
                    2'd1:    lane_load[1] = 1'b1;
                    default: lane_load[2] = 1'b1;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lane_reg <= 8'h00;
                end else if (lane_load[gi]) begin
                    lane_reg <= byte_in;
                end
            end
            assign wr_data[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 2'd0;
            px_reg         <= 10'd0;
            line_reg       <= 10'd0;
            byte_ready_reg <= 1'b0;
            wr_en_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A start coinciding with the frame_done pulse is deliberately dropped.
                    if (start && !frame_done_reg) begin
                        state_reg      <= WAIT_SOF;
                        px_reg         <= 10'd0;
                        line_reg       <= 10'd0;
                        cnt_reg        <= 2'd0;
                        byte_ready_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end
                WAIT_SOF: begin
                    if (byte_valid && byte_sof) begin
                        cnt_reg   <= 2'd1;
                        state_reg <= ACC;
                    end
                end
                ACC: begin
                    if (byte_valid) begin
                        if (byte_sof) begin
                            sync_err_reg <= 1'b1;
                            px_reg       <= 10'd0;
                            line_reg     <= 10'd0;
                            cnt_reg      <= 2'd1;
                        end else if (cnt_reg == 2'd2) begin
                            state_reg      <= WRITE;
                            byte_ready_reg <= 1'b0;
                            wr_en_reg      <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_en_reg <= 1'b0;
                        cnt_reg   <= 2'd0;
                        if (px_reg == H_LAST) begin
                            px_reg <= 10'd0;
                            if (line_reg == V_LAST) begin
                                line_reg       <= 10'd0;
                                state_reg      <= IDLE;
                                busy_reg       <= 1'b0;
                                frame_done_reg <= 1'b1;
                            end else begin
                                line_reg       <= line_reg + 10'd1;
                                state_reg      <= ACC;
                                byte_ready_reg <= 1'b1;
                            end
                        end else begin
                            px_reg         <= px_reg + 10'd1;
                            state_reg      <= ACC;
                            byte_ready_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign byte_ready = byte_ready_reg;
    assign wr_en      = wr_en_reg;
    assign wr_px      = px_reg;
    assign wr_line    = line_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed plus random bench for frame_write_ctrl on a 4x2 frame, checked
// cycle by cycle against a transaction-level reference model.
module tb_frame_write_ctrl;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_sof = 1'b0;
    logic        byte_ready;
    logic        wr_ready = 1'b1;
    logic        wr_en;
    logic [23:0] wr_data;
    logic [9:0]  wr_px;
    logic [9:0]  wr_line;
    logic        busy;
    logic        frame_done;
    logic        sync_err;

    frame_write_ctrl #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_sof(byte_sof), .byte_ready(byte_ready),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_data(wr_data), .wr_px(wr_px),
        .wr_line(wr_line), .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: frame armed, hunting for sof, partial pixel as a byte
    // queue, one pending write, linear pixel index within the frame.
    bit          m_busy, m_hunt, m_pend, m_done, m_err;
    int          m_n;
    logic [7:0]  m_q[$];
    logic [23:0] m_data;

    typedef struct {logic [9:0] line; logic [9:0] px; logic [23:0] data;} wr_t;
    wr_t wlog[$];
    int  ndone = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_hunt = 0; m_pend = 0; m_done = 0; m_err = 0;
        m_n = 0; m_q.delete(); m_data = 24'h0;
    endtask

    task automatic model_edge();
        bit done_old;
        done_old = m_done;
        m_done = 0;
        m_err  = 0;
        if (!m_busy) begin
            if (start && !done_old) begin
                m_busy = 1; m_hunt = 1; m_n = 0; m_q.delete();
            end
        end else if (m_pend) begin
            if (wr_ready) begin
                m_pend = 0;
                if (m_n == H*V - 1) begin
                    m_busy = 0; m_done = 1; m_n = 0;
                end else begin
                    m_n++;
                end
            end
        end else if (byte_valid) begin
            if (m_hunt) begin
                if (byte_sof) begin
                    m_hunt = 0; m_q.delete(); m_q.push_back(byte_in);
                end
            end else if (byte_sof) begin
                m_err = 1; m_n = 0; m_q.delete(); m_q.push_back(byte_in);
            end else begin
                m_q.push_back(byte_in);
                if (m_q.size() == 3) begin
                    m_pend = 1;
                    m_data = {m_q[2], m_q[1], m_q[0]};
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("byte_ready", 32'(byte_ready), 32'(m_busy && !m_pend));
        chk("wr_en", 32'(wr_en), 32'(m_pend));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("sync_err", 32'(sync_err), 32'(m_err));
        chk("wr_px", 32'(wr_px), 32'(m_n % H));
        chk("wr_line", 32'(wr_line), 32'(m_n / H));
        if (m_pend) chk("wr_data", 32'(wr_data), 32'(m_data));
    endtask

    task automatic step();
        if (wr_en && wr_ready) wlog.push_back('{wr_line, wr_px, wr_data});
        @(posedge clk);
        model_edge();
        #1;
        if (frame_done) ndone++;
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof);
        bit got;
        got = 0;
        byte_in = b; byte_valid = 1'b1; byte_sof = sof;
        for (int k = 0; k < 64 && !got; k++) begin
            got = byte_ready;
            step();
        end
        byte_valid = 1'b0; byte_sof = 1'b0;
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL send_timeout observed=0 expected=1 byte=%0h", b);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_outputs();
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        model_reset();
        #12;
        check_outputs();
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        reset = 1'b1;

        // Reset mid-ACC with two bytes buffered.
        start = 1'b1; step(); start = 1'b0;
        send_byte(8'h50, 1'b1);
        send_byte(8'h51, 1'b0);
        step();
        pulse_reset();

        // Non-sof bytes in WAIT_SOF are discarded.
        wlog.delete();
        start = 1'b1; step(); start = 1'b0;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        step(); step();
        chk("discard_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) chk("discard_data", 32'(wlog[0].data), 32'h332211);
        pulse_reset();

        // Full frame with a 5-cycle stall on pixel 1, start held across frame end.
        wlog.delete();
        d0 = ndone;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            send_byte(8'(i), i == 1);
            if (i == 6) begin
                wr_ready = 1'b0;
                repeat (5) step();
                chk("stall_px", 32'(wr_px), 32'd1);
                wr_ready = 1'b1;
            end
        end
        start = 1'b1;
        repeat (4) step();
        start = 1'b0;
        chk("frame_nwr", 32'(wlog.size()), 32'd8);
        chk("frame_ndone", 32'(ndone - d0), 32'd1);
        if (wlog.size() >= 5) begin
            chk("w0_data", 32'(wlog[0].data), 32'h030201);
            chk("w0_px", 32'(wlog[0].px), 32'd0);
            chk("w3_data", 32'(wlog[3].data), 32'h0C0B0A);
            chk("w3_px", 32'(wlog[3].px), 32'd3);
            chk("w4_data", 32'(wlog[4].data), 32'h0F0E0D);
            chk("w4_line", 32'(wlog[4].line), 32'd1);
        end
        chk("rearmed_busy", 32'(busy), 32'd1);

        // Mid-frame sof after two pixels plus one byte.
        wlog.delete();
        d0 = ndone;
        for (int i = 1; i <= 7; i++) send_byte(8'(8'h40 + i), i == 1);
        send_byte(8'h80, 1'b1);
        for (int i = 1; i <= 23; i++) send_byte(8'(8'h90 + i), 1'b0);
        repeat (3) step();
        chk("resync_nwr", 32'(wlog.size()), 32'd10);
        chk("resync_ndone", 32'(ndone - d0), 32'd1);
        if (wlog.size() >= 3) begin
            chk("resync_lo", 32'(wlog[2].data[7:0]), 32'h80);
            chk("resync_px", 32'(wlog[2].px), 32'd0);
            chk("resync_line", 32'(wlog[2].line), 32'd0);
        end

        // Random traffic, random start pulses and backpressure.
        for (int c = 0; c < 4000; c++) begin
            byte_valid = 1'($urandom_range(0, 1));
            byte_in    = 8'($urandom);
            byte_sof   = ($urandom_range(0, 49) == 0);
            start      = ($urandom_range(0, 9) == 0);
            wr_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        byte_valid = 1'b0; byte_sof = 1'b0; start = 1'b0; wr_ready = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
